// File: rtl/jstk_poller_if.sv
// SPI-side bundle between the joystick poller and the SPI master.
// The poller is the master of this interface: it issues the trigger and the
// command frame, and the SPI block returns ~CS and the received frame.
interface jstk_poller_if;
  logic        spi_trigger;
  logic [39:0] spi_out_bytes;
  logic        spi_cs;
  logic [39:0] spi_in_bytes;

  modport master (
    output spi_trigger,
    output spi_out_bytes,
    input  spi_cs,
    input  spi_in_bytes
  );

  modport slave (
    input  spi_trigger,
    input  spi_out_bytes,
    output spi_cs,
    output spi_in_bytes
  );
endinterface

// File: rtl/jstk_poller.sv
// PMOD joystick poll sequencer.
// Fires one 40-bit SPI transfer per poll period (or on demand), watches ~CS
// for start and end of the transfer, and decodes the returned frame into
// X/Y position and button flags. Only one transfer is ever in flight.
module jstk_poller #(
  parameter int unsigned POLL_CYCLES  = 500000,
  parameter int unsigned REQ_TIMEOUT  = 256,
  parameter int unsigned XFER_TIMEOUT = 8192
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jstk_poller_if.master        spi,
  input  logic                 poll_now_i,
  input  logic [1:0]           led_i,
  output logic [9:0]           x_pos_o,
  output logic [9:0]           y_pos_o,
  output logic [2:0]           buttons_o,
  output logic                 sample_valid_o,
  output logic                 busy_o,
  output logic                 timeout_err_o
);

  localparam int unsigned PCW     = $clog2(POLL_CYCLES + 1);
  localparam int unsigned TMO_MAX = (REQ_TIMEOUT > XFER_TIMEOUT) ? REQ_TIMEOUT : XFER_TIMEOUT;
  localparam int unsigned TCW     = $clog2(TMO_MAX + 1);
  localparam logic [39:0] CMD_RST = 40'h80_0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    XFER   = 2'd2,
    DECODE = 2'd3
  } state_t;

  state_t           state_q;
  logic [PCW-1:0]   poll_cnt_q;
  logic [PCW-1:0]   poll_cnt_d;
  logic             tick;
  logic             cs_q;
  logic             cs_rise;
  logic             cs_fall;
  logic             pending_q;
  logic [TCW-1:0]   tmo_q;
  logic             trigger_q;
  logic [39:0]      out_bytes_q;
  logic [9:0]       x_q;
  logic [9:0]       y_q;
  logic [2:0]       btn_q;
  logic             sv_q;
  logic             busy_q;
  logic             terr_q;

  // Frame bits carrying no position/button information.
  logic             unused_bits;
  assign unused_bits = ^{spi.spi_in_bytes[29:24], spi.spi_in_bytes[13:8], spi.spi_in_bytes[7:3]};

  // Poll timer next value and the end-of-period tick.
  always_comb begin
    tick       = (poll_cnt_q == PCW'(POLL_CYCLES - 1));
    poll_cnt_d = tick ? '0 : poll_cnt_q + 1'b1;
  end

  // Edges of ~CS relative to its registered copy.
  assign cs_rise = spi.spi_cs & ~cs_q;
  assign cs_fall = ~spi.spi_cs & cs_q;

  // Free-running poll timer, independent of sequencer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) poll_cnt_q <= '0;
    else        poll_cnt_q <= poll_cnt_d;
  end

  // Single register stage on ~CS for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cs_q <= 1'b1;
    else        cs_q <= spi.spi_cs;
  end

  // Poll sequencer: request, transfer, decode, with timeouts and one-deep pending poll.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      tmo_q       <= '0;
      trigger_q   <= 1'b0;
      out_bytes_q <= CMD_RST;
      x_q         <= '0;
      y_q         <= '0;
      btn_q       <= '0;
      sv_q        <= 1'b0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      sv_q <= 1'b0;
      // Requests arriving while busy collapse into a single pending poll.
      if (state_q != IDLE && (tick || poll_now_i)) pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (tick || poll_now_i || pending_q) begin
            state_q     <= REQ;
            pending_q   <= 1'b0;
            trigger_q   <= 1'b1;
            busy_q      <= 1'b1;
            out_bytes_q <= {6'b100000, led_i[1], led_i[0], 32'h0};
          end
        end
        REQ: begin
          if (cs_fall) begin
            state_q   <= XFER;
            trigger_q <= 1'b0;
            tmo_q     <= '0;
          end else if (tmo_q == TCW'(REQ_TIMEOUT - 1)) begin
            state_q   <= IDLE;
            trigger_q <= 1'b0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b1;
            tmo_q     <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        XFER: begin
          if (cs_rise) begin
            state_q <= DECODE;
            tmo_q   <= '0;
          end else if (tmo_q == TCW'(XFER_TIMEOUT - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            terr_q  <= 1'b1;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        DECODE: begin
          x_q     <= {spi.spi_in_bytes[31:30], spi.spi_in_bytes[39:32]};
          y_q     <= {spi.spi_in_bytes[15:14], spi.spi_in_bytes[23:16]};
          btn_q   <= spi.spi_in_bytes[2:0];
          sv_q    <= 1'b1;
          terr_q  <= 1'b0;
          busy_q  <= 1'b0;
          tmo_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          trigger_q <= 1'b0;
          busy_q    <= 1'b0;
          tmo_q     <= '0;
        end
      endcase
    end
  end

  assign spi.spi_trigger   = trigger_q;
  assign spi.spi_out_bytes = out_bytes_q;
  assign x_pos_o           = x_q;
  assign y_pos_o           = y_q;
  assign buttons_o         = btn_q;
  assign sample_valid_o    = sv_q;
  assign busy_o            = busy_q;
  assign timeout_err_o     = terr_q;

endmodule

// File: tb/tb_jstk_poller.sv
// Bench for the joystick poll sequencer: a behavioural SPI responder with
// random timing and frames, plus a decode reference computed arithmetically.
module tb_jstk_poller;
  localparam int P  = 2000;
  localparam int RT = 64;
  localparam int XT = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       poll_now = 1'b0;
  logic [1:0] led = 2'b00;
  logic [9:0] x_pos, y_pos;
  logic [2:0] buttons;
  logic       sample_valid, busy, timeout_err;

  jstk_poller_if bus ();

  jstk_poller #(.POLL_CYCLES(P), .REQ_TIMEOUT(RT), .XFER_TIMEOUT(XT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spi           (bus),
    .poll_now_i    (poll_now),
    .led_i         (led),
    .x_pos_o       (x_pos),
    .y_pos_o       (y_pos),
    .buttons_o     (buttons),
    .sample_valid_o(sample_valid),
    .busy_o        (busy),
    .timeout_err_o (timeout_err)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference decode of a received frame, from byte positions.
  function automatic logic [9:0] ref_x(input logic [39:0] f);
    return 10'(((f >> 30) & 40'd3) * 256 + ((f >> 32) & 40'd255));
  endfunction
  function automatic logic [9:0] ref_y(input logic [39:0] f);
    return 10'(((f >> 14) & 40'd3) * 256 + ((f >> 16) & 40'd255));
  endfunction
  function automatic logic [2:0] ref_btn(input logic [39:0] f);
    return 3'(f % 8);
  endfunction
  function automatic logic [39:0] ref_cmd(input logic [1:0] l);
    return 40'(128 + int'(l)) << 32;
  endfunction

  // Edges seen since reset release: the poll timer ticks every P edges.
  int pe = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pe <= 0;
    else        pe <= pe + 1;
  end

  // SPI responder: mode 0 normal, 1 ignores trigger, 2 holds cs low until released.
  int          mode = 0;
  int          hold_lo = 3;
  int          hold_hi = 20;
  bit          cs_release = 1'b0;
  logic [39:0] rsp_q[$];
  logic [39:0] sent_q[$];

  initial begin
    logic [39:0] cmd;
    logic [39:0] f;
    bus.spi_cs       = 1'b1;
    bus.spi_in_bytes = '0;
    forever begin
      @(negedge clk);
      if (mode != 1 && bus.spi_trigger === 1'b1) begin
        cmd = bus.spi_out_bytes;
        check("cmd_frame", cmd, ref_cmd(led));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        #1 bus.spi_cs = 1'b0;
        if (mode == 2) begin
          while (!cs_release) @(negedge clk);
          #1 bus.spi_cs = 1'b1;
        end else begin
          repeat ($urandom_range(hold_lo, hold_hi)) @(negedge clk);
          if (rsp_q.size() != 0) f = rsp_q.pop_front();
          else begin
            f[39:32] = 8'($urandom);
            f[31:0]  = $urandom;
          end
          #1 bus.spi_in_bytes = f;
          sent_q.push_back(f);
          @(negedge clk);
          check("cmd_hold", bus.spi_out_bytes, cmd);
          #1 bus.spi_cs = 1'b1;
        end
      end
    end
  end

  // Output monitor: counts pulses/triggers and checks every decoded sample.
  int   n_samp = 0, n_trig = 0, ncyc = 0, last_sv = 0, last_tr = 0;
  logic trig_prev = 1'b0, cs_h1 = 1'b1, cs_h2 = 1'b1;
  always @(negedge clk) begin
    logic [39:0] f;
    ncyc <= ncyc + 1;
    if (sample_valid) begin
      n_samp  <= n_samp + 1;
      last_sv <= ncyc;
      check("sv_latency", {61'd0, cs_h2, cs_h1, bus.spi_cs}, 64'b011);
      if (sent_q.size() == 0) check("spurious_sample", 64'd1, 64'd0);
      else begin
        f = sent_q.pop_front();
        check("x_pos", x_pos, ref_x(f));
        check("y_pos", y_pos, ref_y(f));
        check("buttons", buttons, ref_btn(f));
        check("terr_on_sample", timeout_err, 1'b0);
      end
    end
    if (bus.spi_trigger && !trig_prev) begin
      n_trig  <= n_trig + 1;
      last_tr <= ncyc;
    end
    trig_prev <= bus.spi_trigger;
    cs_h2     <= cs_h1;
    cs_h1     <= bus.spi_cs;
  end

  task automatic align(input int ph);
    int i = 0;
    @(negedge clk);
    while ((pe % P) != ph && i < P + 5) begin @(negedge clk); i++; end
    if (i >= P + 5) check("align_timeout", 64'd1, 64'd0);
  endtask

  task automatic pulse_poll();
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
  endtask

  task automatic wait_samp(input int target, input int budget, input string tag);
    int i = 0;
    while (n_samp < target && i < budget) begin @(negedge clk); i++; end
    @(negedge clk);
    check(tag, n_samp, target);
  endtask

  task automatic wait_cs_low(input int budget, input string tag);
    int i = 0;
    while (bus.spi_cs !== 1'b0 && i < budget) begin @(negedge clk); i++; end
    check(tag, bus.spi_cs, 1'b0);
  endtask

  initial begin
    int base_s, base_t, s1, cnt;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_trigger", bus.spi_trigger, 1'b0);
    check("rst_out_bytes", bus.spi_out_bytes, 40'h80_0000_0000);
    check("rst_x", x_pos, 10'd0);
    check("rst_y", y_pos, 10'd0);
    check("rst_buttons", buttons, 3'd0);
    check("rst_sv", sample_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_terr", timeout_err, 1'b0);

    // First automatic poll after one full period
    rsp_q.push_back(40'h34_02_C1_01_05);
    rst_n = 1'b1;
    cnt = 0;
    while (bus.spi_trigger !== 1'b1 && cnt < P + 10) begin @(negedge clk); cnt++; end
    check("t1_first_trig_edge", pe, P);
    check("t1_busy_req", busy, 1'b1);
    wait_samp(1, 100, "t1_samples");
    check("t1_x", x_pos, ref_x(40'h34_02_C1_01_05));
    check("t1_y", y_pos, ref_y(40'h34_02_C1_01_05));
    check("t1_btn", buttons, 3'b101);
    repeat (3) @(negedge clk);
    check("t1_busy_after", busy, 1'b0);
    check("t1_one_pulse", n_samp, 1);

    // On-demand poll with LED frame; LED change mid-transfer must not leak in
    align(100);
    led = 2'b10; hold_lo = 30; hold_hi = 40;
    pulse_poll();
    wait_cs_low(20, "t2_cs_fall");
    check("t2_cmd", bus.spi_out_bytes, 40'h82_0000_0000);
    led = 2'b01;
    repeat (5) @(negedge clk);
    check("t2_cmd_mid", bus.spi_out_bytes, 40'h82_0000_0000);
    wait_samp(2, 100, "t2_samples");
    hold_lo = 3; hold_hi = 20;

    // Request timeout: cs never falls
    align(100);
    mode = 1;
    base_s = n_samp;
    pulse_poll();
    cnt = 0;
    while (bus.spi_trigger === 1'b1 && cnt < RT + 20) begin cnt++; @(negedge clk); end
    check("t3_trig_len", cnt, RT);
    check("t3_terr", timeout_err, 1'b1);
    check("t3_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("t3_no_sample", n_samp, base_s);
    mode = 0;
    pulse_poll();
    wait_samp(base_s + 1, 100, "t3_recover");
    check("t3_terr_clear", timeout_err, 1'b0);

    // poll_now and timer tick together during a transfer -> one extra poll
    align(P - 100);
    hold_lo = 120; hold_hi = 140;
    base_s = n_samp; base_t = n_trig;
    pulse_poll();
    align(P - 1);
    check("t4_in_xfer", {bus.spi_cs, bus.spi_trigger}, 2'b00);
    pulse_poll();
    wait_samp(base_s + 1, 300, "t4_first");
    s1 = last_sv;
    wait_samp(base_s + 2, 300, "t4_second");
    check("t4_gap", last_tr - s1, 1);
    align(P - 50);
    check("t4_samples", n_samp - base_s, 2);
    check("t4_triggers", n_trig - base_t, 2);
    hold_lo = 3; hold_hi = 20;

    // Reset while transfer in flight
    align(100);
    mode = 2;
    base_s = n_samp;
    pulse_poll();
    wait_cs_low(20, "t5_cs_fall");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_trigger", bus.spi_trigger, 1'b0);
    check("t5_out_bytes", bus.spi_out_bytes, 40'h80_0000_0000);
    check("t5_xy", {x_pos, y_pos}, 20'd0);
    check("t5_buttons", buttons, 3'd0);
    check("t5_busy", busy, 1'b0);
    check("t5_terr_sv", {timeout_err, sample_valid}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    cs_release = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_sample", n_samp, base_s);
    check("t5_idle", busy, 1'b0);
    mode = 0;
    cs_release = 1'b0;

    // Back-to-back automatic polls over twenty periods
    align(500);
    base_s = n_samp; base_t = n_trig;
    for (int i = 0; i < 20; i++) begin
      align(1000);
      led = 2'($urandom);
      align(500);
    end
    check("t6_samples", n_samp - base_s, 20);
    check("t6_triggers", n_trig - base_t, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
